// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the reduced RISC-V core.
// Accepts one instruction word per handshake and decodes it. It then drives the
// ALU controls and the memory, register-file and PC strobes across the EXEC,
// MEM and WB phases. Only one instruction is in flight at a time.
//
// Optional feature: define CTRL_TRAP_EN to halt in a TRAP state on an illegal
// instruction. When it is undefined, an illegal instruction retires as a NOP.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in FETCH)
//   instr                    32-bit instruction word
//   eq                       ALU equality flag, used to resolve branches
//   mem_done                 data-memory access complete
//   alusrc, aluctrl, immop   ALU operand select, operation, sign-extended imm
//   rs1, rs2, rd             register fields of the held instruction
//   regwrite, memtoreg       register-file write strobe and writeback source
//   memread, memwrite        data-memory request, held until mem_done
//   pc_en, pcsrc             one-cycle PC update, 1 = branch target
//   trap                     illegal-instruction halt
//
// States:
//   FETCH  | waiting for an instruction (instr_ready = 1)
//   DECODE | classify IR, register immop
//   EXEC   | ALU controls driven, branches resolve here
//   MEM    | load/store request held until mem_done
//   WB     | register write (R/I/lw), PC+4
//   TRAP   | illegal instruction halt until reset (CTRL_TRAP_EN only)
module multicycle_ctrl #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic               eq,
  input  logic               mem_done,
  output logic               alusrc,
  output logic [2:0]         aluctrl,
  output logic [D_WIDTH-1:0] immop,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic               regwrite,
  output logic               memtoreg,
  output logic               memread,
  output logic               memwrite,
  output logic               pc_en,
  output logic               pcsrc,
  output logic               trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_ILL} cls_t;

  state_t             state;
  logic [31:0]        ir;
  cls_t               cls;
  logic [2:0]         dec_alu;
  logic               dec_src;
  logic [D_WIDTH-1:0] imm_ext;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  // Instruction classification and ALU controls, a pure function of IR so the
  // values stay stable through EXEC and MEM without extra registers.
  always_comb begin
    cls     = C_ILL;
    dec_alu = 3'b000;
    dec_src = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'b0000000) begin cls = C_ALU; dec_alu = 3'b000; end
        else if (f3 == 3'b000 && f7 == 7'b0100000) begin cls = C_ALU; dec_alu = 3'b001; end
        else if (f3 == 3'b111 && f7 == 7'b0000000) begin cls = C_ALU; dec_alu = 3'b010; end
        else if (f3 == 3'b110 && f7 == 7'b0000000) begin cls = C_ALU; dec_alu = 3'b011; end
      end
      7'b0010011: begin
        dec_src = 1'b1;
        if (f3 == 3'b000)      begin cls = C_ALU; dec_alu = 3'b000; end
        else if (f3 == 3'b111) begin cls = C_ALU; dec_alu = 3'b010; end
        else if (f3 == 3'b110) begin cls = C_ALU; dec_alu = 3'b011; end
      end
      7'b0000011: begin
        dec_src = 1'b1;
        if (f3 == 3'b010) cls = C_LW;
      end
      7'b0100011: begin
        dec_src = 1'b1;
        if (f3 == 3'b010) cls = C_SW;
      end
      7'b1100011: begin
        dec_alu = 3'b001;
        if (f3 == 3'b000)      cls = C_BEQ;
        else if (f3 == 3'b001) cls = C_BNE;
      end
      default: cls = C_ILL;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (opcode)
      7'b0010011, 7'b0000011:
        imm_ext = {{(D_WIDTH-12){ir[31]}}, ir[31:20]};
      7'b0100011:
        imm_ext = {{(D_WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011:
        imm_ext = {{(D_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
      immop <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          immop <= imm_ext;
          if (cls == C_ILL) begin
`ifdef CTRL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls == C_BEQ || cls == C_BNE)     state <= S_FETCH;
          else if (cls == C_LW || cls == C_SW)  state <= S_MEM;
          else                                  state <= S_WB;
        end
        S_MEM: begin
          if (mem_done) state <= (cls == C_LW) ? S_WB : S_FETCH;
        end
        S_WB: state <= S_FETCH;
`ifdef CTRL_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes are decoded from the state register and IR; the branch and store
  // PC pulses also depend on eq / mem_done within the same cycle.
  always_comb begin
    instr_ready = (state == S_FETCH);
    alusrc      = 1'b0;
    aluctrl     = 3'b000;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    pc_en       = 1'b0;
    pcsrc       = 1'b0;
    trap        = 1'b0;
    case (state)
      S_DECODE: begin
`ifndef CTRL_TRAP_EN
        if (cls == C_ILL) pc_en = 1'b1;
`endif
      end
      S_EXEC: begin
        aluctrl = dec_alu;
        alusrc  = dec_src;
        if (cls == C_BEQ) begin pc_en = 1'b1; pcsrc = eq;  end
        if (cls == C_BNE) begin pc_en = 1'b1; pcsrc = ~eq; end
      end
      S_MEM: begin
        aluctrl  = dec_alu;
        alusrc   = dec_src;
        memread  = (cls == C_LW);
        memwrite = (cls == C_SW);
        if (cls == C_SW && mem_done) pc_en = 1'b1;
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = (cls == C_LW);
        pc_en    = 1'b1;
      end
`ifdef CTRL_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        eq;
  logic        mem_done;
  logic        alusrc;
  logic [2:0]  aluctrl;
  logic [31:0] immop;
  logic [4:0]  rs1, rs2, rd;
  logic        regwrite, memtoreg, memread, memwrite, pc_en, pcsrc, trap;

  int n_vec = 0;
  int n_bad = 0;

  multicycle_ctrl #(.D_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .eq(eq), .mem_done(mem_done), .alusrc(alusrc),
    .aluctrl(aluctrl), .immop(immop), .rs1(rs1), .rs2(rs2), .rd(rd),
    .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .pc_en(pc_en), .pcsrc(pcsrc), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        eq;
    int          lat;      // mem_done asserted in this MEM cycle
    logic        noise;    // drive mem_done outside MEM
    logic        illegal;
    logic        chk_imm;
    int          e_cyc;    // cycles from accept until FETCH again
    logic [2:0]  e_alu;
    logic        e_src;
    logic [31:0] e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_pcsrc;
    int          e_rw;
    logic        e_mtr;
    int          e_mrd, e_mwr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic [31:0] i, input logic e, input int lat, input logic nz,
    input logic ill, input logic ci, input int cyc, input logic [2:0] alu,
    input logic src, input logic [31:0] imm, input logic [4:0] a, input logic [4:0] b,
    input logic [4:0] d, input logic ps, input int rw, input logic mtr,
    input int mrd, input int mwr);
    vec_t v;
    v.instr = i; v.eq = e; v.lat = lat; v.noise = nz; v.illegal = ill; v.chk_imm = ci;
    v.e_cyc = cyc; v.e_alu = alu; v.e_src = src; v.e_imm = imm;
    v.e_rs1 = a; v.e_rs2 = b; v.e_rd = d; v.e_pcsrc = ps; v.e_rw = rw;
    v.e_mtr = mtr; v.e_mrd = mrd; v.e_mwr = mwr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int got_cyc = 99, pcn = 0, pcidx = -1, rw = 0, mrd = 0, mwr = 0, mc = 0, trp = 0;
    logic pcs = 1'b0, mtr = 1'b0, as = 1'bx;
    logic [2:0]  ac = 3'bx;
    logic [31:0] im = 'x;
    logic [4:0]  r1 = 'x, r2 = 'x, rdv = 'x;
    @(negedge clk);
    check($sformatf("v%0d ready_before", k), {31'd0, instr_ready}, 32'd1);
    instr = v.instr; instr_valid = 1'b1; eq = v.eq; mem_done = 1'b0;
    @(posedge clk); #1;
    // Keep a valid garbage word on the bus while busy; it must not be taken.
    instr = 32'hFFFFFFFF; instr_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (memread || memwrite) begin
        mc++;
        mem_done = (mc == v.lat);
      end else begin
        mem_done = v.noise;
      end
      #1;
      if (c == 2) begin ac = aluctrl; as = alusrc; im = immop; end
      if (instr_ready) begin
        got_cyc = c; instr_valid = 1'b0; mem_done = 1'b0;
        break;
      end
      r1 = rs1; r2 = rs2; rdv = rd;
      if (pc_en) begin pcn++; pcidx = c; pcs = pcsrc; end
      if (regwrite) begin rw++; mtr = memtoreg; end
      if (memread) mrd++;
      if (memwrite) mwr++;
      if (trap) trp++;
    end
    instr_valid = 1'b0; mem_done = 1'b0;
    check($sformatf("v%0d cycles", k), got_cyc, v.e_cyc);
    check($sformatf("v%0d aluctrl", k), {29'd0, ac}, {29'd0, v.e_alu});
    check($sformatf("v%0d alusrc", k), {31'd0, as}, {31'd0, v.e_src});
    if (v.chk_imm) check($sformatf("v%0d immop", k), im, v.e_imm);
    check($sformatf("v%0d rs1", k), {27'd0, r1}, {27'd0, v.e_rs1});
    check($sformatf("v%0d rs2", k), {27'd0, r2}, {27'd0, v.e_rs2});
    check($sformatf("v%0d rd", k), {27'd0, rdv}, {27'd0, v.e_rd});
    check($sformatf("v%0d pc_en_count", k), pcn, 1);
    check($sformatf("v%0d pc_en_cycle", k), pcidx, v.e_cyc - 1);
    check($sformatf("v%0d pcsrc", k), {31'd0, pcs}, {31'd0, v.e_pcsrc});
    check($sformatf("v%0d regwrite_count", k), rw, v.e_rw);
    check($sformatf("v%0d memtoreg", k), {31'd0, mtr}, {31'd0, v.e_mtr});
    check($sformatf("v%0d memread_cycles", k), mrd, v.e_mrd);
    check($sformatf("v%0d memwrite_cycles", k), mwr, v.e_mwr);
    check($sformatf("v%0d trap_cycles", k), trp, 0);
  endtask

  initial begin
    //           instr         eq lat nz ill ci cyc alu    src imm           rs1 rs2 rd ps rw mtr mrd mwr
    vt.push_back(mk(32'h002081B3, 0, 0, 0, 0, 0, 4, 3'b000, 0, 32'h0,        1,  2,  3, 0, 1, 0, 0, 0)); // add
    vt.push_back(mk(32'hFFF00293, 0, 0, 1, 0, 1, 4, 3'b000, 1, 32'hFFFFFFFF, 0, 31,  5, 0, 1, 0, 0, 0)); // addi -1
    vt.push_back(mk(32'h402081B3, 0, 0, 0, 0, 0, 4, 3'b001, 0, 32'h0,        1,  2,  3, 0, 1, 0, 0, 0)); // sub
    vt.push_back(mk(32'h0020F1B3, 0, 0, 0, 0, 0, 4, 3'b010, 0, 32'h0,        1,  2,  3, 0, 1, 0, 0, 0)); // and
    vt.push_back(mk(32'h0020E1B3, 0, 0, 0, 0, 0, 4, 3'b011, 0, 32'h0,        1,  2,  3, 0, 1, 0, 0, 0)); // or
    vt.push_back(mk(32'h8000E313, 0, 0, 0, 0, 1, 4, 3'b011, 1, 32'hFFFFF800, 1,  0,  6, 0, 1, 0, 0, 0)); // ori -2048
    vt.push_back(mk(32'h7FF17393, 0, 0, 0, 0, 1, 4, 3'b010, 1, 32'h000007FF, 2, 31,  7, 0, 1, 0, 0, 0)); // andi 2047
    vt.push_back(mk(32'h00208033, 0, 0, 0, 0, 0, 4, 3'b000, 0, 32'h0,        1,  2,  0, 0, 1, 0, 0, 0)); // add x0
    vt.push_back(mk(32'h0080A203, 0, 3, 0, 0, 1, 7, 3'b000, 1, 32'h8,        1,  8,  4, 0, 1, 1, 3, 0)); // lw N=3
    vt.push_back(mk(32'h0080A203, 1, 1, 1, 0, 1, 5, 3'b000, 1, 32'h8,        1,  8,  4, 0, 1, 1, 1, 0)); // lw N=1
    vt.push_back(mk(32'hFE20AE23, 0, 2, 0, 0, 1, 5, 3'b000, 1, 32'hFFFFFFFC, 1,  2, 28, 0, 0, 0, 0, 2)); // sw N=2
    vt.push_back(mk(32'hFE20AE23, 1, 1, 1, 0, 1, 4, 3'b000, 1, 32'hFFFFFFFC, 1,  2, 28, 0, 0, 0, 0, 1)); // sw N=1
    vt.push_back(mk(32'hFE208CE3, 1, 0, 0, 0, 1, 3, 3'b001, 0, 32'hFFFFFFF8, 1,  2, 25, 1, 0, 0, 0, 0)); // beq taken
    vt.push_back(mk(32'hFE208CE3, 0, 0, 0, 0, 1, 3, 3'b001, 0, 32'hFFFFFFF8, 1,  2, 25, 0, 0, 0, 0, 0)); // beq not
    vt.push_back(mk(32'hFE209CE3, 1, 0, 0, 0, 1, 3, 3'b001, 0, 32'hFFFFFFF8, 1,  2, 25, 0, 0, 0, 0, 0)); // bne not
    vt.push_back(mk(32'hFE209CE3, 0, 0, 1, 0, 1, 3, 3'b001, 0, 32'hFFFFFFF8, 1,  2, 25, 1, 0, 0, 0, 0)); // bne taken
    vt.push_back(mk(32'hFFFFFFFF, 0, 0, 0, 1, 0, 2, 3'b000, 0, 32'h0,       31, 31, 31, 0, 0, 0, 0, 0)); // illegal
    vt.push_back(mk(32'h602081B3, 0, 0, 0, 1, 0, 2, 3'b000, 0, 32'h0,        1,  2,  3, 0, 0, 0, 0, 0)); // bad f7
    vt.push_back(mk(32'h00008203, 0, 0, 0, 1, 0, 2, 3'b000, 0, 32'h0,        1,  0,  4, 0, 0, 0, 0, 0)); // lb

    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; eq = 1'b0; mem_done = 1'b0;
    #12;
    check("reset ready", {31'd0, instr_ready}, 32'd1);
    check("reset immop", immop, 32'd0);
    check("reset fields", {17'd0, rs1, rs2, rd}, 32'd0);
    check("reset strobes", {22'd0, aluctrl, alusrc, regwrite, memtoreg, memread, memwrite, pc_en, pcsrc, trap}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post-reset ready", {31'd0, instr_ready}, 32'd1);
    check("post-reset strobes", {25'd0, regwrite, memread, memwrite, pc_en, trap, aluctrl[0], alusrc}, 32'd0);

    foreach (vt[k]) begin
`ifdef CTRL_TRAP_EN
      if (!vt[k].illegal) run_vec(vt[k], k);
`else
      run_vec(vt[k], k);
`endif
    end

    // Reset in the middle of a load.
    begin
      int seen = 0, bad = 0;
      @(negedge clk);
      instr = 32'h0080A203; instr_valid = 1'b1; mem_done = 1'b0;
      @(posedge clk); #1; instr_valid = 1'b0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
        @(negedge clk);
        if (memread) seen = 1;
      end
      check("rst_mem memread_reached", seen, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mem memread_drop", {31'd0, memread}, 32'd0);
      check("rst_mem no_strobes", {30'd0, regwrite, pc_en}, 32'd0);
      check("rst_mem ready_in_reset", {31'd0, instr_ready}, 32'd1);
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (regwrite || pc_en || memread || !instr_ready) bad++;
      end
      check("rst_mem quiet_after", bad, 0);
      check("rst_mem rd_cleared", {27'd0, rd}, 32'd0);
    end

`ifdef CTRL_TRAP_EN
    begin
      int strb = 0, notrap = 0;
      @(negedge clk);
      instr = 32'hFFFFFFFF; instr_valid = 1'b1;
      @(posedge clk); #1; instr_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      check("trap asserted", {31'd0, trap}, 32'd1);
      check("trap ready_low", {31'd0, instr_ready}, 32'd0);
      instr = 32'h002081B3; instr_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (pc_en || regwrite || memread || memwrite || instr_ready) strb++;
        if (!trap) notrap++;
      end
      instr_valid = 1'b0;
      check("trap strobes_quiet", strb, 0);
      check("trap held", notrap, 0);
      rst = 1'b1; #3;
      check("trap cleared_by_rst", {30'd0, trap, instr_ready}, 32'd1);
      @(negedge clk); rst = 1'b0;
    end
`endif

    // A plain instruction after everything still completes normally.
    run_vec(vt[0], 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the reduced RISC-V core, and the driving end of the ALU control interface. It accepts one instruction word per handshake and decodes it, producing `alusrc`, `aluctrl` and a sign-extended `immop` for the ALU. It consumes the ALU `eq` flag to resolve branches, then steps through the memory and writeback phases with register-file, data-memory and PC strobes. Exactly one instruction is in flight; there is no pipelining.

## Interface
- `D_WIDTH`, 32: datapath width; `immop` is sign-extended to this width.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `instr_valid`  in  1  instruction word on `instr` is valid
- `instr_ready`  out  1  sequencer can accept an instruction (FETCH state)
- `instr`  in  32  instruction word
- `eq`  in  1  ALU equality flag (`aluop1 == aluop2`)
- `mem_done`  in  1  data-memory access complete
- `alusrc`  out  1  1 = ALU operand 2 from `immop`, 0 = from register
- `aluctrl`  out  3  000 add, 001 sub, 010 and, 011 or
- `immop`  out  D_WIDTH  sign-extended immediate
- `rs1`, `rs2`, `rd`  out  5 each  register fields of the held instruction
- `regwrite`  out  1  register-file write strobe
- `memtoreg`  out  1  writeback source is memory (lw)
- `memread`, `memwrite`  out  1 each  data-memory request, held until `mem_done`
- `pc_en`  out  1  one-cycle PC update pulse
- `pcsrc`  out  1  valid with `pc_en`: 1 = branch target, 0 = PC+4
- `trap`  out  1  illegal instruction halt (see Configuration)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: `instr_ready`=1. On `instr_valid`, the word is captured into the instruction register (IR) and the next state is DECODE.
- DECODE:
  - The instruction is classified.
  - `immop` is registered: I-type `instr[31:20]`; S-type `{instr[31:25],instr[11:7]}`; B-type `{instr[31],instr[7],instr[30:25],instr[11:8],1'b0}`. All are sign-extended.
  - A legal instruction goes to EXEC.
- Legal set and decoding:
  - R-type, opcode 0110011: add (f3 000, f7 0000000), sub (f3 000, f7 0100000), and (f3 111), or (f3 110). `alusrc`=0.
  - I-type, opcode 0010011: addi (000), andi (111), ori (110). `alusrc`=1.
  - lw (0000011, f3 010) and sw (0100011, f3 010): aluctrl add, `alusrc`=1.
  - beq (1100011, f3 000) and bne (f3 001): aluctrl sub, `alusrc`=0.
  - Every other encoding is illegal, including an R-type f7 other than those listed.
- EXEC: `aluctrl`/`alusrc` are driven.
  - R/I: go to WB.
  - lw/sw: go to MEM.
  - Branch: `pc_en`=1 with `pcsrc`=`eq` (beq) or `~eq` (bne); go to FETCH.
- MEM: `memread` (lw) or `memwrite` (sw) is held, together with the EXEC `aluctrl`/`alusrc`, until `mem_done`.
  - lw: go to WB.
  - sw: `pc_en`=1, `pcsrc`=0 in the `mem_done` cycle; go to FETCH.
- WB: `regwrite`=1, `memtoreg`=1 for lw only, `pc_en`=1, `pcsrc`=0; go to FETCH.
- Outputs are decoded from the state register and IR. `aluctrl`=000 and `alusrc`=0 outside EXEC/MEM. `rs1`/`rs2`/`rd` always reflect the IR.

## Timing
- Reset (async assert, sync release):
  - State is FETCH and IR = 0.
  - `instr_ready`=1.
  - `immop`, `aluctrl`, `rs1`, `rs2`, `rd` = 0.
  - All other outputs = 0.
- Latency, counted from the accept cycle:
  - R/I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - sw: 3 cycles + N MEM cycles.
  - lw: 4 cycles + N MEM cycles.
  - N ≥ 1; `mem_done` in the first MEM cycle gives N=1.
- `instr_valid` outside FETCH is ignored, and `instr` is not sampled.
- `mem_done` outside MEM is ignored.
- `pc_en` is exactly one cycle per retired instruction.
- `rst` mid-instruction: FETCH is entered immediately. Any pending MEM request is dropped and no `regwrite`/`pc_en` is issued.
- Writes to `rd`=x0 are still strobed; the register file discards them.

## Configuration
- `CTRL_TRAP_EN` defined:
  - An illegal instruction goes DECODE → TRAP.
  - In TRAP, `trap`=1 and `instr_ready`=0, with all strobes 0, until reset.
- Undefined:
  - An illegal instruction is a NOP: DECODE issues `pc_en`=1, `pcsrc`=0 and returns to FETCH.
  - `trap` is tied 0 and the TRAP state does not exist.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) → `rs1`=1, `rs2`=2, `rd`=3, `aluctrl`=000, `alusrc`=0 in EXEC. In WB, `regwrite`=1 and `pc_en`=1; 4 cycles total.
- `addi x5,x0,-1` (0xFFF00293) → `immop`=0xFFFFFFFF, `alusrc`=1; `sub` (0x402081B3) → `aluctrl`=001.
- `lw x4,8(x1)` (0x0080A203) with `mem_done` after 3 cycles → `memread` held 3 cycles, then WB with `memtoreg`=1. `sw x2,-4(x1)` (0xFE20AE23) → `immop`=0xFFFFFFFC, and `pc_en` in the `mem_done` cycle.
- `beq x1,x2,-8` (0xFE208CE3) with `eq`=1 → `immop`=0xFFFFFFF8, `pc_en`=1, `pcsrc`=1. `bne` (0xFE209CE3) with `eq`=1 → `pcsrc`=0.
- Illegal word 0xFFFFFFFF:
  - With `CTRL_TRAP_EN`: `trap`=1, `instr_ready`=0, and further `instr_valid` is ignored until `rst`.
  - Without: a single `pc_en` pulse, then FETCH.
- Assert `rst` during MEM with `memread`=1 → `memread` drops asynchronously, with no `regwrite`, and `instr_ready`=1 after release.
